// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, address type and zero-register index helper
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // Index of the architectural zero register (XZR): the top entry of the file.
  function automatic int xzr_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with set-over-clear priority
// and a registered popcount of the busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NWRITE      = 2,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NWRITE-1:0]        we_i,
  input  logic [NWRITE*ADDR_W-1:0] wa_i,
  input  logic                     bset_en_i,
  input  logic [ADDR_W-1:0]        bset_addr_i,
  output logic [2**ADDR_W-1:0]     busy_o,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int NREG = 2**ADDR_W;
  localparam int CW   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(xzr_idx(ADDR_W));

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    clr = '0;
    for (int k = 0; k < NWRITE; k++) begin
      if (we_i[k]) clr[wa_i[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // A retiring producer clears its bit unless a new producer is issued to the
  // same register on this edge.
  always_comb begin
    busy_d = busy_q & ~clr;
    if (bset_en_i) busy_d[bset_addr_i] = 1'b1;
    if (ZERO_REG_EN) busy_d[XZR] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with optional write bypass,
// zero register and busy scoreboard for issue-time hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NREAD       = 2,
  parameter int NWRITE      = 2,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NWRITE-1:0]        we_i,
  input  logic [NWRITE*ADDR_W-1:0] wa_i,
  input  logic [NWRITE*DATA_W-1:0] wd_i,
  input  logic [NREAD*ADDR_W-1:0]  ra_i,
  output logic [NREAD*DATA_W-1:0]  rd_o,
  output logic [NREAD-1:0]         rbusy_o,
  input  logic                     bset_en_i,
  input  logic [ADDR_W-1:0]        bset_addr_i,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(xzr_idx(ADDR_W));

  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("regfile_mp: NREAD must be in 1..4");
  end
  if (NWRITE < 1 || NWRITE > 2) begin : g_bad_nwrite
    $error("regfile_mp: NWRITE must be in 1..2");
  end

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   busy;

  regfile_scoreboard #(
    .ADDR_W      (ADDR_W),
    .NWRITE      (NWRITE),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .we_i        (we_i),
    .wa_i        (wa_i),
    .bset_en_i   (bset_en_i),
    .bset_addr_i (bset_addr_i),
    .busy_o      (busy),
    .busy_cnt_o  (busy_cnt_o)
  );

  // Ports are applied in ascending order so the highest-index writer wins.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (we_i[k] && !(ZERO_REG_EN && wa_i[k*ADDR_W +: ADDR_W] == XZR)) begin
        mem_d[wa_i[k*ADDR_W +: ADDR_W]] = wd_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [ADDR_W-1:0] ra_j;
  logic [DATA_W-1:0] val_j;
  logic              hit_j;

  // A forwarded write means the producer has just retired, so the read is not
  // busy unless another producer to that register is issued this same cycle.
  always_comb begin
    rd_o    = '0;
    rbusy_o = '0;
    ra_j    = '0;
    val_j   = '0;
    hit_j   = 1'b0;
    for (int j = 0; j < NREAD; j++) begin
      ra_j  = ra_i[j*ADDR_W +: ADDR_W];
      val_j = mem_q[ra_j];
      hit_j = 1'b0;
      if (BYPASS_EN) begin
        for (int k = 0; k < NWRITE; k++) begin
          if (we_i[k] && wa_i[k*ADDR_W +: ADDR_W] == ra_j) begin
            val_j = wd_i[k*DATA_W +: DATA_W];
            hit_j = 1'b1;
          end
        end
      end
      rd_o[j*DATA_W +: DATA_W] = val_j;
      rbusy_o[j] = busy[ra_j] && !(hit_j && !(bset_en_i && bset_addr_i == ra_j));
      if (ZERO_REG_EN && ra_j == XZR) begin
        rd_o[j*DATA_W +: DATA_W] = '0;
        rbusy_o[j]               = 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the ARMv8 pipelined datapath; successor to the single-write, two-read regfile.
- Provides NREAD combinational read ports and NWRITE write ports.
- Optional write-to-read bypass and a zero register.
- Per-register busy scoreboard: decode uses it to detect pending producers before issue.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, address width; depth NREG = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- NWRITE, 2, number of write ports (1..2).
- ZERO_REG_EN, 1, when 1 the top register (NREG-1, XZR) reads 0, ignores writes and is never busy.
- BYPASS_EN, 1, when 1 a same-cycle write is forwarded to matching reads.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, synchronous active-high reset.
- we, in, NWRITE, per-port write enable.
- wa, in, NWRITE*ADDR_W, packed write addresses; port k = wa[k*ADDR_W +: ADDR_W].
- wd, in, NWRITE*DATA_W, packed write data.
- ra, in, NREAD*ADDR_W, packed read addresses.
- rd, out, NREAD*DATA_W, packed read data.
- rbusy, out, NREAD, busy flag of each read address.
- bset_en, in, 1, mark register bset_addr busy (instruction issued).
- bset_addr, in, ADDR_W, destination being issued.
- busy_cnt, out, ADDR_W+1, number of registers currently busy.

Behaviour:
- Reset (clk edge with reset=1):
  - Register i <- i, zero-extended to DATA_W; XZR reads 0 when ZERO_REG_EN.
  - All busy bits cleared; busy_cnt = 0.
  - Reset overrides any we/bset_en in the same cycle.
- Reads are combinational, zero cycles.
  - Without bypass, rd shows the value committed at the last edge.
  - A write at edge N is visible on rd from the cycle after N.
- Bypass (BYPASS_EN=1): if we[k] && wa[k]==ra[j] this cycle, rd[j] = wd[k]; highest k wins.
- Bypass (BYPASS_EN=0): old value until the edge.
- Write conflict: several ports writing the same address in one cycle -> highest-index port wins, in both storage and bypass.
- Zero register (ZERO_REG_EN=1, addr NREG-1):
  - rd = 0 regardless of bypass.
  - Writes are dropped; bset_en to it is ignored; rbusy = 0.
- Zero register (ZERO_REG_EN=0): addr NREG-1 is an ordinary register.
- Scoreboard, per-register busy bit b[i], next state:
  - set if bset_en && bset_addr==i;
  - else clear if any we[k] && wa[k]==i;
  - else hold.
  - Set beats clear on the same edge: a new producer is issued while the old one retires.
- rbusy[j] = b[ra[j]].
  - With BYPASS_EN, rbusy[j] is forced 0 when a same-cycle write to ra[j] exists and no bset of that address is pending this cycle.
- busy_cnt is registered: the popcount of the busy vector after the edge.
  - Never exceeds NREG, or NREG-1 with ZERO_REG_EN.
- Writes to non-busy registers are legal; the busy bit stays 0.
- Setting an already-busy register leaves it busy; no nesting count.
- X and out-of-range parameter values are not checked at runtime; elaboration asserts 1<=NREAD<=4 and 1<=NWRITE<=2.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants, XZR_IDX function (2**ADDR_W-1), typedef reg_addr_t.
- One sub-module, regfile_scoreboard: busy vector, set/clear priority, popcount.
- The storage array, bypass muxing and zero-register masking stay in regfile_mp.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd == index for 0..30; rd == 0 for 31; busy_cnt == 0.
- we[0]=1, wa[0]=14, wd[0]=64'hFFFF_AAAA_FFFF_CCCC, ra[0]=14 in the same cycle:
  - BYPASS_EN=1 -> rd0 = new value immediately.
  - BYPASS_EN=0 -> rd0 = 14 until after the edge.
  - With we=0 the value stays 14.
- Both ports write addr 7 (wd0=0x11, wd1=0x22) -> rd on 7 = 0x22 after the edge and on bypass.
- Write 64'hDEAD to addr 31, and bset_en on 31 -> rd = 0, rbusy = 0, busy_cnt unchanged.
- bset_en addr 5 -> next cycle rbusy = 1 and busy_cnt = 1.
  - Then bset 5 and write 5 in the same cycle -> stays busy.
  - Then write 5 alone -> busy clears, busy_cnt = 0.
  - Bypass-cycle rbusy = 0.
- Set busy on regs 1..4, write reg 2 = 0x55, assert reset with we=1 on reg 3 -> after the edge all regs hold their index, busy_cnt = 0, reg 3 = 3.
